// File: rtl/music_sequencer.sv
// Note-table driven sequencer: plays a list of {freq, duration, rest, last}
// entries into an audio channel, with optional looping and abort.
module music_sequencer #(
    parameter int TICK_DIV = 3125000,
    parameter int DEPTH    = 32,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [2:0]        gen_sel_i,
    input  logic [7:0]        volume_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [23:0]       wr_data_i,
    output logic              ch_en_o,
    output logic [15:0]       ch_freq_o,
    output logic [2:0]        ch_gen_sel_o,
    output logic [7:0]        ch_volume_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] note_idx_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_PLAY
    } state_t;

    state_t            r_state, w_state_next;
    logic [21:0]       r_table [DEPTH];
    logic [CNT_W-1:0]  r_unit, w_unit_next;
    logic [3:0]        r_dur_cnt, w_dur_cnt_next;
    logic [3:0]        r_dur, w_dur_next;
    logic              r_final, w_final_next;
    logic [ADDR_W-1:0] r_idx, w_idx_next;
    logic              r_en, w_en_next;
    logic [15:0]       r_freq, w_freq_next;
    logic [2:0]        r_gen, w_gen_next;
    logic [7:0]        r_vol, w_vol_next;
    logic              r_done, w_done_next;

    logic              w_load;
    logic [ADDR_W-1:0] w_load_idx;
    logic [21:0]       w_entry;
    logic              w_unit_end;
    logic              w_entry_end;
    logic              w_unused;

    assign w_unused = ^wr_data_i[23:22];

    // One register per table entry so the whole table clears on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_table[gi] <= '0;
                end else if (wr_en_i && (wr_addr_i == ADDR_W'(gi))) begin
                    r_table[gi] <= wr_data_i[21:0];
                end
            end
        end
    endgenerate

    // A load is only ever of entry 0 (start/loop) or the successor entry.
    assign w_load_idx  = (r_state == ST_PLAY && !r_final) ? r_idx + 1'b1 : '0;
    assign w_entry     = r_table[w_load_idx];
    assign w_unit_end  = (r_unit == CNT_W'(TICK_DIV - 1));
    assign w_entry_end = w_unit_end && (r_dur_cnt == r_dur);

    always_comb begin
        w_state_next   = r_state;
        w_unit_next    = r_unit;
        w_dur_cnt_next = r_dur_cnt;
        w_dur_next     = r_dur;
        w_final_next   = r_final;
        w_idx_next     = r_idx;
        w_en_next      = r_en;
        w_freq_next    = r_freq;
        w_gen_next     = r_gen;
        w_vol_next     = r_vol;
        w_done_next    = 1'b0;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_en_next = 1'b0;
                if (start_i && !stop_i) begin
                    w_state_next = ST_PLAY;
                    w_load       = 1'b1;
                    w_gen_next   = gen_sel_i;
                    w_vol_next   = volume_i;
                end
            end
            ST_PLAY: begin
                if (stop_i) begin
                    w_state_next   = ST_IDLE;
                    w_en_next      = 1'b0;
                    w_unit_next    = '0;
                    w_dur_cnt_next = '0;
                end else if (w_entry_end) begin
                    if (!r_final || loop_i) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next   = ST_IDLE;
                        w_en_next      = 1'b0;
                        w_done_next    = 1'b1;
                        w_unit_next    = '0;
                        w_dur_cnt_next = '0;
                    end
                end else if (w_unit_end) begin
                    w_unit_next    = '0;
                    w_dur_cnt_next = r_dur_cnt + 4'd1;
                end else begin
                    w_unit_next = r_unit + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_idx_next     = w_load_idx;
            w_freq_next    = w_entry[15:0];
            w_dur_next     = w_entry[19:16];
            w_en_next      = ~w_entry[20];
            w_final_next   = w_entry[21] || (w_load_idx == ADDR_W'(DEPTH - 1));
            w_unit_next    = '0;
            w_dur_cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= ST_IDLE;
            r_unit    <= '0;
            r_dur_cnt <= '0;
            r_dur     <= '0;
            r_final   <= 1'b0;
            r_idx     <= '0;
            r_en      <= 1'b0;
            r_freq    <= '0;
            r_gen     <= '0;
            r_vol     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_unit    <= w_unit_next;
            r_dur_cnt <= w_dur_cnt_next;
            r_dur     <= w_dur_next;
            r_final   <= w_final_next;
            r_idx     <= w_idx_next;
            r_en      <= w_en_next;
            r_freq    <= w_freq_next;
            r_gen     <= w_gen_next;
            r_vol     <= w_vol_next;
            r_done    <= w_done_next;
        end
    end

    assign ch_en_o      = r_en;
    assign ch_freq_o    = r_freq;
    assign ch_gen_sel_o = r_gen;
    assign ch_volume_o  = r_vol;
    assign busy_o       = (r_state == ST_PLAY);
    assign done_o       = r_done;
    assign note_idx_o   = r_idx;

endmodule
